// File: rtl/cpu_md_pkg.sv
`default_nettype none
// ============================================================================
// cpu_md_pkg : function codes, FSM states and decode helpers for cpu_ex_muldiv
// Revision   : 1.0 - initial release
// ============================================================================
package cpu_md_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // mult/multu/div/divu occupy 0x18..0x1b
  function automatic logic is_md_start(input logic [5:0] func);
    return (func[5:2] == 4'b0110);
  endfunction

  // any of the eight HI/LO unit functions (0x10..0x13, 0x18..0x1b)
  function automatic logic is_md_func(input logic [5:0] func);
    return is_md_start(func) || (func[5:2] == 4'b0100);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_md_iter.sv
`default_nettype none
// ============================================================================
// cpu_md_iter : one-bit-per-cycle shift-add multiply / restoring divide core
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_md_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             done
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // multiply keeps the multiplier in r_q and shifts product bits into it;
  // divide shifts dividend bits out of r_q and quotient bits back in
  always_comb begin
    w_sum   = {1'b0, r_acc} + {1'b0, ({WIDTH{r_q[0]}} & r_b)};
    w_shift = {r_acc, r_q[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_b});
    w_diff  = w_shift[WIDTH-1:0] - r_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_q   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_acc <= '0;
      r_q   <= a;
      r_b   <= b;
      r_cnt <= '0;
    end else if (step) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (is_div) begin
        r_acc <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_ge};
      end else begin
        r_acc <= w_sum[WIDTH:1];
        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      end
    end
  end

  assign acc_hi = r_acc;
  assign acc_lo = r_q;
  assign done   = step && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_ex_muldiv.sv
`default_nettype none
// ============================================================================
// cpu_ex_muldiv : EX-stage multiply/divide unit with HI/LO and pipeline stall
// Revision      : 1.0 - initial release
// ============================================================================
module cpu_ex_muldiv
  import cpu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_c_md,
  input  logic [5:0]       id_func,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             stall,
  output logic [WIDTH-1:0] md_r,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  md_state_e r_state;
  md_state_e w_state_nxt;

  logic w_start;
  logic w_step;
  logic w_fix;
  logic w_done;
  logic w_signed;

  logic r_div;
  logic r_neg_q;
  logic r_neg_r;
  logic r_dz;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_abs_x;
  logic [WIDTH-1:0]   w_abs_y;
  logic [WIDTH-1:0]   w_it_hi;
  logic [WIDTH-1:0]   w_it_lo;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_step   = (r_state == ST_BUSY);
  assign w_signed = ~id_func[0];
  assign w_abs_x  = (w_signed && x[WIDTH-1]) ? -x : x;
  assign w_abs_y  = (w_signed && y[WIDTH-1]) ? -y : y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (id_c_md && is_md_start(id_func)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_done) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_start) begin
      r_div   <= id_func[1];
      r_neg_q <= w_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
      r_neg_r <= w_signed && x[WIDTH-1];
      r_dz    <= (y == '0);
    end
  end

  cpu_md_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .step   (w_step),
    .is_div (r_div),
    .a      (w_abs_x),
    .b      (w_abs_y),
    .acc_hi (w_it_hi),
    .acc_lo (w_it_lo),
    .done   (w_done)
  );

  // a zero divisor leaves the dividend in the remainder naturally; only the
  // quotient needs forcing, since its sign correction would otherwise apply
  assign w_prod_fix = r_neg_q ? -{w_it_hi, w_it_lo} : {w_it_hi, w_it_lo};
  assign w_quo_fix  = r_dz ? '1 : (r_neg_q ? -w_it_lo : w_it_lo);
  assign w_rem_fix  = r_neg_r ? -w_it_hi : w_it_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fix) begin
      if (r_div) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end else begin
        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
        r_lo <= w_prod_fix[WIDTH-1:0];
      end
    end else if ((r_state == ST_IDLE) && id_c_md) begin
      if (id_func == FN_MTHI) r_hi <= x;
      if (id_func == FN_MTLO) r_lo <= x;
    end
  end

  always_comb begin
    md_r = '0;
    if (id_c_md && (id_func == FN_MFHI)) md_r = r_hi;
    if (id_c_md && (id_func == FN_MFLO)) md_r = r_lo;
  end

  assign busy  = (r_state != ST_IDLE);
  assign stall = id_c_md && is_md_func(id_func) && busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ex_muldiv.sv
`default_nettype none
// ============================================================================
// tb_cpu_ex_muldiv : scoreboard bench for cpu_ex_muldiv (WIDTH 32 and 8)
// Revision         : 1.0 - initial release
// ============================================================================
module tb_cpu_ex_muldiv;
  import cpu_md_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        id_c_md;
  logic [5:0]  id_func;
  logic [31:0] x, y, md_r, hi, lo;
  logic        stall, busy;

  logic        c8;
  logic [5:0]  f8;
  logic [7:0]  x8, y8, mdr8, hi8, lo8;
  logic        stall8, busy8;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] sb_q[$];

  cpu_ex_muldiv #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .id_c_md(id_c_md), .id_func(id_func), .x(x), .y(y),
    .stall(stall), .md_r(md_r), .hi(hi), .lo(lo), .busy(busy)
  );

  cpu_ex_muldiv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .id_c_md(c8), .id_func(f8), .x(x8), .y(y8),
    .stall(stall8), .md_r(mdr8), .hi(hi8), .lo(lo8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // reference {HI, LO} for the 32-bit unit
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, b);
    logic signed [63:0] pa, pb;
    logic signed [31:0] da, db, dq, dr;
    pa = $signed(a);
    pb = $signed(b);
    da = a;
    db = b;
    model = '0;
    case (f)
      FN_MULT:  model = pa * pb;
      FN_MULTU: model = {32'b0, a} * {32'b0, b};
      FN_DIV: begin
        if (b == 32'd0) model = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = {32'd0, a};
        else begin
          dq = da / db;
          dr = da % db;
          model = {dr, dq};
        end
      end
      FN_DIVU: begin
        if (b == 32'd0) model = {a, 32'hFFFFFFFF};
        else model = {a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  // present an op until it is accepted; report stall cycles and md_r at accept
  task automatic issue(input logic [5:0] f, input logic [31:0] a, b,
                       output int stalls, output logic [31:0] r);
    @(negedge clk);
    id_c_md = 1'b1; id_func = f; x = a; y = b;
    stalls = 0;
    #1;
    while (stall && stalls < 200) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stall) chk("issue_timeout", stall, 1'b0);
    r = md_r;
    @(posedge clk); #1;
    id_c_md = 1'b0; id_func = 6'd0;
  endtask

  task automatic start_op(input logic [5:0] f, input logic [31:0] a, b, output int st);
    logic [31:0] r;
    sb_q.push_back(model(f, a, b));
    issue(f, a, b, st, r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic run8(input logic [5:0] f, input logic [7:0] a, b, input logic [15:0] exp);
    int n;
    @(negedge clk);
    c8 = 1'b1; f8 = f; x8 = a; y8 = b;
    @(negedge clk);
    c8 = 1'b0;
    n = 0;
    while (busy8 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("w8_latency", n, 9);
    chk("w8_hilo", {hi8, lo8}, exp);
  endtask

  // completion monitor: every busy->idle transition not caused by rst pops one result
  initial begin : mon
    logic prev;
    int cyc;
    logic [63:0] e;
    prev = 1'b0;
    cyc  = 0;
    forever begin
      @(negedge clk);
      if (busy) cyc++;
      else if (prev) begin
        if (!rst) begin
          chk("sb_nonempty", sb_q.size() != 0, 1'b1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("hilo", {hi, lo}, e);
            chk("latency", cyc, 33);
          end
        end
        cyc = 0;
      end
      prev = busy;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : main
    int st;
    logic [31:0] r, a, b;
    logic [5:0] f;
    rst = 1'b1; id_c_md = 1'b0; id_func = 6'd0; x = '0; y = '0;
    c8 = 1'b0; f8 = 6'd0; x8 = '0; y8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_md_r", md_r, 0);
    #1 rst = 1'b0;

    start_op(FN_MULT, 32'hFFFFFFFD, 32'd7, st);
    issue(FN_MFHI, 0, 0, st, r);
    chk("mfhi_stall", st, 33);
    chk("mfhi_val", r, 32'hFFFFFFFF);
    issue(FN_MFLO, 0, 0, st, r);
    chk("mflo_stall", st, 0);
    chk("mflo_val", r, 32'hFFFFFFEB);

    start_op(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, st);
    start_op(FN_MULT, 32'd6, 32'hFFFFFFFE, st);
    chk("b2b_stall", st, 33);
    start_op(FN_DIV, 32'hFFFFFFF9, 32'd2, st);
    start_op(FN_DIVU, 32'd100, 32'd7, st);
    start_op(FN_DIV, 32'd5, 32'd0, st);
    start_op(FN_DIV, 32'hFFFFFFFB, 32'd0, st);
    start_op(FN_DIVU, 32'd9, 32'd0, st);
    start_op(FN_DIV, 32'h80000000, 32'hFFFFFFFF, st);
    for (int i = 0; i < 8; i++) begin
      f = FN_MULT + 6'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      start_op(f, a, b, st);
    end
    wait_idle();

    issue(FN_MTHI, 32'h1234, 0, st, r);
    chk("mthi_stall", st, 0);
    issue(FN_MFHI, 0, 0, st, r);
    chk("mfhi_idle_stall", st, 0);
    chk("mfhi_after_mthi", r, 32'h1234);
    issue(FN_MTLO, 32'hABCD0001, 0, st, r);
    issue(FN_MFLO, 0, 0, st, r);
    chk("mflo_after_mtlo", r, 32'hABCD0001);

    @(negedge clk);
    id_c_md = 1'b0; id_func = FN_MFHI;
    #1 chk("md_r_not_md", md_r, 0);
    id_c_md = 1'b1; id_func = 6'h20;
    #1 chk("unk_stall", stall, 0);
    chk("unk_md_r", md_r, 0);
    @(posedge clk); #1;
    chk("unk_busy", busy, 0);
    id_c_md = 1'b0; id_func = 6'd0;

    start_op(FN_DIVU, 32'hDEADBEEF, 32'h1234, st);
    @(negedge clk);
    id_c_md = 1'b0; id_func = FN_MFHI;
    #1 chk("nonmd_stall", stall, 0);
    chk("nonmd_busy", busy, 1);
    wait_idle();

    issue(FN_DIV, 32'h07654321, 32'd3, st, r);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    chk("rstmid_hi", hi, 0);
    chk("rstmid_lo", lo, 0);
    chk("rstmid_busy", busy, 0);
    id_c_md = 1'b1; id_func = FN_MFHI;
    #1 chk("rstmid_stall", stall, 0);
    @(posedge clk); #1;
    id_c_md = 1'b0; id_func = 6'd0;

    run8(FN_MULTU, 8'hFF, 8'hFF, 16'hFE01);
    run8(FN_DIV, 8'h80, 8'hFF, 16'h0080);
    run8(FN_DIV, 8'hF9, 8'h02, 16'hFFFD);

    repeat (2) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_ex_muldiv.md
# cpu_ex_muldiv

Parametrised multiply/divide unit for the execute stage, next generation of the single-cycle EX ALU. It adds MIPS-style `mult`/`multu`/`div`/`divu` as iterative multi-cycle operations, plus architectural HI/LO registers and `mfhi`/`mflo`/`mthi`/`mtlo`. It sits beside the EX ALU, takes the already-forwarded operands, and raises `stall` to hold the front of the pipeline when an instruction needs a busy unit.

## Interface
- `WIDTH`, 32: operand, HI and LO width; even, ≥4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `id_c_md`  in  1  the EX-stage instruction is a mul/div-unit op.
- `id_func`  in  6  function code: 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu.
- `x`  in  WIDTH  forwarded rs operand.
- `y`  in  WIDTH  forwarded rt operand.
- `stall`  out  1  hold IF/ID/EX this cycle; the op is not accepted.
- `md_r`  out  WIDTH  combinational mfhi/mflo result, feeds the EX result mux.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, BUSY, FIX.
- IDLE + `id_c_md` + func 0x18–0x1b:
  - Latch |x| and |y| (signed ops) or x and y (unsigned ops).
  - Latch the result signs.
  - Clear the counter; go to BUSY.
- BUSY: one iteration per cycle.
  - Multiply: shift-add, 2·WIDTH-bit product.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - After WIDTH iterations, go to FIX.
- FIX, one cycle, then IDLE:
  - Apply the signs: the product, the quotient and the remainder are negated per the MIPS rules; the remainder takes the dividend's sign.
  - Write HI/LO. Multiply: HI = upper half, LO = lower half. Divide: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = x. This holds for both signed and unsigned divide.
- Signed overflow (min ÷ −1): LO = min, HI = 0. This falls out of the magnitude datapath.
- mthi/mtlo in IDLE: HI/LO ← x at the next edge.
- mfhi/mflo in IDLE: `md_r` = HI/LO, same cycle.
- `md_r` = 0 when `id_c_md` = 0 or the func is not mfhi/mflo.
- `stall` = `id_c_md` & (state ≠ IDLE) for any of the eight funcs. This keeps a new op from clobbering one in flight and keeps a read from seeing stale HI/LO.
- Unknown func with `id_c_md`: no state change, no stall.

## Timing
- Reset: state IDLE, counter 0, `hi` = `lo` = 0, `stall` = 0, `busy` = 0, `md_r` = 0.
- Accept at edge E0. BUSY runs from E0 to E_WIDTH. FIX writes HI/LO at edge E_(WIDTH+1).
- Latency: WIDTH+1 cycles. An mfhi issued right after a mult stalls WIDTH+1 cycles and reads the new value in the cycle after E_(WIDTH+1).
- Non-md instructions issue freely while the unit is BUSY.
- A stalled instruction is re-presented unchanged by the pipeline. It is accepted in the first cycle the state is IDLE.
- `rst` during BUSY/FIX: the op is abandoned; HI/LO = 0 at the next edge.
- Back-to-back mult with no gap: the second stalls until IDLE, then starts. There is no overlap.
- All arithmetic is modulo 2^WIDTH per register. Negation is two's complement.

## Structure
- Package `cpu_md_pkg`:
  - func code constants (FN_MFHI…FN_DIVU);
  - state enum;
  - helper function `is_md_start(func)`.
- Sub-module `cpu_md_iter`: the WIDTH-parametrised shift-add/shift-subtract datapath (accumulator, operand shift registers, counter, done pulse).
- The top level holds the FSM, sign fix-up, HI/LO, stall and the read mux.

## Test plan
- mult x = −3 (0xFFFFFFFD), y = 7 → after 33 cycles, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; mfhi issued next cycle stalls exactly 33 cycles.
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- div −7 ÷ 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; divu 100 ÷ 7 → LO = 14, HI = 2.
- Boundaries:
  - div 5 ÷ 0 → LO = 0xFFFFFFFF, HI = 5;
  - div 0x80000000 ÷ −1 → LO = 0x80000000, HI = 0.
- mthi 0x1234 then mflo/mfhi in IDLE → no stall, `md_r` = 0x1234 for mfhi the same cycle; a second mult issued during BUSY stalls until IDLE, then completes correctly.
- `rst` pulse at iteration 10 of a div → IDLE, HI = LO = 0, `stall` = 0 next cycle. Rerun with WIDTH = 8: multu 255 × 255 → HI = 0xFE, LO = 0x01 after 9 cycles.
